// File: rtl/score_ram_writer.sv
// Write-port sequencer for the Needleman-Wunsch score RAM: gap-penalty
// border initialisation followed by per-cell score writes.
module score_ram_writer #(
    parameter int N           = 128,
    parameter int BitAddr     = $clog2(N + 1),
    parameter int addr_lenght = $clog2(((N + 1) * (N + 1)) - 1),
    parameter int SCORE_W     = 10,
    parameter int signed GAP  = -2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      cell_valid,
    input  logic signed [SCORE_W-1:0] cell_score,
    input  logic [BitAddr:0]          i,
    input  logic [BitAddr:0]          j,
    input  logic                      finish,
    output logic                      we,
    output logic [addr_lenght:0]      addr,
    output logic signed [SCORE_W-1:0] data_out,
    output logic                      cell_ack,
    output logic                      init_done,
    output logic                      idx_err
);

    localparam int AW = addr_lenght + 1;
    localparam int IW = BitAddr + 1;

    typedef enum logic [2:0] {
        IDLE,
        INIT_ROW,
        INIT_COL,
        READY,
        WRITE
    } state_t;

    localparam logic [IW-1:0]             K_LAST = IW'(N);
    localparam logic [AW-1:0]             ROW_W  = AW'(N + 1);
    localparam logic signed [SCORE_W-1:0] GAP_S  = SCORE_W'(GAP);

    state_t                      state_q;
    logic [IW-1:0]               k_q;
    logic                        we_q;
    logic [AW-1:0]               addr_q;
    logic signed [SCORE_W-1:0]   data_q;
    logic                        cell_ack_q;
    logic                        init_done_q;
    logic                        idx_err_q;

    logic [AW-1:0] cell_addr_d;
    logic          in_range;

    // Cell (i+1, j+1) sits one row and one column past its diagonal neighbour.
    assign cell_addr_d = (AW'(j) + AW'(1)) + ROW_W * (AW'(i) + AW'(1));
    assign in_range    = (i < K_LAST) && (j < K_LAST);

    // addr_q/data_q double as the address and value accumulators during init.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cell_ack_q  <= 1'b0;
            init_done_q <= 1'b0;
            idx_err_q   <= 1'b0;
        end else begin
            cell_ack_q <= 1'b0;
            idx_err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    we_q        <= 1'b0;
                    init_done_q <= 1'b0;
                    if (start) begin
                        state_q <= INIT_ROW;
                        k_q     <= '0;
                        addr_q  <= '0;
                        data_q  <= '0;
                        we_q    <= 1'b1;
                    end
                end
                INIT_ROW: begin
                    we_q <= 1'b1;
                    if (k_q == K_LAST) begin
                        state_q <= INIT_COL;
                        k_q     <= IW'(1);
                        addr_q  <= ROW_W;
                        data_q  <= GAP_S;
                    end else begin
                        k_q    <= k_q + IW'(1);
                        addr_q <= addr_q + AW'(1);
                        data_q <= data_q + GAP_S;
                    end
                end
                INIT_COL: begin
                    if (k_q == K_LAST) begin
                        state_q     <= READY;
                        we_q        <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        we_q   <= 1'b1;
                        k_q    <= k_q + IW'(1);
                        addr_q <= addr_q + ROW_W;
                        data_q <= data_q + GAP_S;
                    end
                end
                READY: begin
                    we_q <= 1'b0;
                    if (finish) begin
                        state_q     <= IDLE;
                        init_done_q <= 1'b0;
                    end else if (cell_valid) begin
                        if (in_range) begin
                            state_q    <= WRITE;
                            addr_q     <= cell_addr_d;
                            data_q     <= cell_score;
                            we_q       <= 1'b1;
                            cell_ack_q <= 1'b1;
                        end else begin
                            idx_err_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    we_q <= 1'b0;
                    if (finish) begin
                        state_q     <= IDLE;
                        init_done_q <= 1'b0;
                    end else begin
                        state_q <= READY;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    we_q        <= 1'b0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign we        = we_q;
    assign addr      = addr_q;
    assign data_out  = data_q;
    assign cell_ack  = cell_ack_q;
    assign init_done = init_done_q;
    assign idx_err   = idx_err_q;

endmodule

// File: tb/tb_score_ram_writer.sv
// Directed bench for score_ram_writer with N=4, GAP=-2.
module tb_score_ram_writer;

    localparam int N  = 4;
    localparam int SW = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 cell_valid;
    logic signed [SW-1:0] cell_score;
    logic [3:0]           ti;
    logic [3:0]           tj;
    logic                 finish;
    logic                 we;
    logic [5:0]           addr;
    logic signed [SW-1:0] data_out;
    logic                 cell_ack;
    logic                 init_done;
    logic                 idx_err;

    int checks   = 0;
    int failures = 0;

    score_ram_writer #(
        .N(N), .SCORE_W(SW), .GAP(-2)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cell_valid(cell_valid), .cell_score(cell_score),
        .i(ti), .j(tj), .finish(finish),
        .we(we), .addr(addr), .data_out(data_out),
        .cell_ack(cell_ack), .init_done(init_done),
        .idx_err(idx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] i;
        logic [3:0] j;
        int         score;
        int         ew;
        int         ea;
        int         ed;
        int         eerr;
    } vec_t;

    vec_t tv[8];
    int   init_a[9] = '{0, 1, 2, 3, 4, 5, 10, 15, 20};
    int   init_d[9] = '{0, -2, -4, -6, -8, -2, -4, -6, -8};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!init_done && n < 30) begin
            step();
            n++;
        end
        chk("wait_init_done", int'(init_done), 1);
    endtask

    initial begin
        logic [3:0] pulses;
        int         cnt;

        tv[0] = '{4'd0, 4'd0, 1,    1, 6,  1,    0};
        tv[1] = '{4'd3, 4'd3, -3,   1, 24, -3,   0};
        tv[2] = '{4'd1, 4'd2, 100,  1, 13, 100,  0};
        tv[3] = '{4'd2, 4'd0, -50,  1, 16, -50,  0};
        tv[4] = '{4'd4, 4'd1, 9,    0, 0,  0,    1};
        tv[5] = '{4'd0, 4'd4, 9,    0, 0,  0,    1};
        tv[6] = '{4'd3, 4'd0, 511,  1, 21, 511,  0};
        tv[7] = '{4'd15, 4'd15, 5,  0, 0,  0,    1};

        rst = 1'b1; start = 1'b0; cell_valid = 1'b0;
        cell_score = '0; ti = '0; tj = '0; finish = 1'b0;
        step();
        chk("rst_we", int'(we), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_data", int'($signed(data_out)), 0);
        chk("rst_ack", int'(cell_ack), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_idx_err", int'(idx_err), 0);
        rst = 1'b0;
        step();

        // init, with a cell request held throughout
        start = 1'b1;
        cell_valid = 1'b1; ti = 4'd1; tj = 4'd1; cell_score = 10'sd7;
        step();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("init_we_%0d", k), int'(we), 1);
            chk($sformatf("init_addr_%0d", k), int'(addr), init_a[k]);
            chk($sformatf("init_data_%0d", k),
                int'($signed(data_out)), init_d[k]);
            chk($sformatf("init_ack_%0d", k), int'(cell_ack), 0);
            chk($sformatf("init_done_lo_%0d", k), int'(init_done), 0);
            step();
        end
        chk("ready_init_done", int'(init_done), 1);
        chk("ready_we", int'(we), 0);
        chk("ready_ack", int'(cell_ack), 0);
        step();
        chk("held_init_ack", int'(cell_ack), 1);
        chk("held_init_we", int'(we), 1);
        chk("held_init_addr", int'(addr), 12);
        chk("held_init_data", int'($signed(data_out)), 7);
        cell_valid = 1'b0;
        step();

        for (int n = 0; n < 8; n++) begin
            ti = tv[n].i; tj = tv[n].j;
            cell_score = SW'(tv[n].score);
            cell_valid = 1'b1;
            step();
            cell_valid = 1'b0;
            chk($sformatf("v%0d_we", n), int'(we), tv[n].ew);
            chk($sformatf("v%0d_ack", n), int'(cell_ack), tv[n].ew);
            chk($sformatf("v%0d_err", n), int'(idx_err), tv[n].eerr);
            if (tv[n].ew != 0) begin
                chk($sformatf("v%0d_addr", n), int'(addr), tv[n].ea);
                chk($sformatf("v%0d_data", n),
                    int'($signed(data_out)), tv[n].ed);
            end
            step();
            chk($sformatf("v%0d_we_after", n), int'(we), 0);
            chk($sformatf("v%0d_err_after", n), int'(idx_err), 0);
            chk($sformatf("v%0d_ready", n), int'(init_done), 1);
        end

        // held valid for 4 sampled edges
        ti = 4'd2; tj = 4'd2; cell_score = 10'sd3;
        cell_valid = 1'b1;
        pulses = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            pulses[c] = we & cell_ack;
        end
        cell_valid = 1'b0;
        chk("held_pulses", int'(pulses), 5);
        step();

        // start in READY must not re-initialise
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ready_we", int'(we), 0);
        chk("start_ready_done", int'(init_done), 1);
        step();
        chk("start_ready_we2", int'(we), 0);

        // finish in READY, later requests ignored
        finish = 1'b1;
        step();
        finish = 1'b0;
        chk("finish_done", int'(init_done), 0);
        cell_valid = 1'b1; ti = 4'd0; tj = 4'd0;
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            cnt += int'(we) + int'(cell_ack) + int'(idx_err);
        end
        cell_valid = 1'b0;
        chk("idle_ignores_valid", cnt, 0);

        // reset at the third init write
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("third_write_addr", int'(addr), 2);
        chk("third_write_data", int'($signed(data_out)), -4);
        rst = 1'b1;
        #1;
        chk("async_rst_we", int'(we), 0);
        chk("async_rst_addr", int'(addr), 0);
        chk("async_rst_data", int'($signed(data_out)), 0);
        step();
        rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_we", int'(we), 1);
        chk("restart_addr", int'(addr), 0);
        chk("restart_data", int'($signed(data_out)), 0);
        wait_init();

        // finish during a WRITE cycle: write completes, then IDLE
        ti = 4'd1; tj = 4'd3; cell_score = -10'sd1;
        cell_valid = 1'b1;
        step();
        cell_valid = 1'b0;
        finish = 1'b1;
        chk("fin_wr_we", int'(we), 1);
        chk("fin_wr_addr", int'(addr), 14);
        step();
        finish = 1'b0;
        chk("fin_wr_done", int'(init_done), 0);
        chk("fin_wr_we_after", int'(we), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
